// File: rtl/switch_pkg.sv
// Shared types and helpers for the 4-port byte switch output scheduler.
// The SWITCH_ARB_BYPASS_EN option lives in switch_out_arbiter; nothing here depends on it.
package switch_pkg;
    localparam int NPORTS     = 4;
    localparam int DW         = 8;
    localparam int AW         = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 16;
    localparam int PW         = $clog2(NPORTS);

    typedef logic [PW-1:0]    port_idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [DW-1:0] data;
        port_idx_t     dst;
    } beat_t;

    typedef struct packed {
        logic      vld;
        port_idx_t idx;
    } pick_t;

    // Scan from the highest offset down so the candidate nearest ptr is the one left standing.
    function automatic pick_t rr_pick(input logic [NPORTS-1:0] req, input port_idx_t ptr);
        pick_t     r;
        port_idx_t k;
        r = '0;
        for (int n = NPORTS - 1; n >= 0; n--) begin
            k = port_idx_t'((int'(ptr) + n) % NPORTS);
            if (req[k]) begin
                r.vld = 1'b1;
                r.idx = k;
            end
        end
        return r;
    endfunction

    function automatic cnt_t sat_add(input cnt_t a, input int n);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(n);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction
endpackage

// File: rtl/switch_in_fifo.sv
// Per-input beat FIFO. Full/empty come from the occupancy count at the start of the cycle,
// so a pop in the same cycle never opens space for a push.
module switch_in_fifo
    import switch_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  i_push,
    input  beat_t i_beat,
    input  logic  i_pop,
    output logic  o_full,
    output logic  o_empty,
    output beat_t o_head
);
    localparam int IW = $clog2(DEPTH);

    beat_t         r_mem [DEPTH];
    logic [IW-1:0] r_wr;
    logic [IW-1:0] r_rd;
    logic [IW:0]   r_cnt;

    assign o_full  = (r_cnt == (IW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + IW'(1);
            if (i_pop)  r_rd <= r_rd + IW'(1);
            r_cnt <= r_cnt + (IW+1)'(i_push) - (IW+1)'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr] <= i_beat;
    end
endmodule

// File: rtl/switch_out_arbiter.sv
// Output-port scheduler: per-input FIFOs, round-robin per output, registered output lanes.
// Define SWITCH_ARB_BYPASS_EN to let a beat arriving at an empty FIFO compete in its arrival cycle.
module switch_out_arbiter
    import switch_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NPORTS-1:0]    valid_in,
    input  logic [NPORTS*DW-1:0] data_in,
    input  logic [NPORTS*AW-1:0] addr_in,
    output logic [NPORTS-1:0]    ready_in,
    output logic [NPORTS-1:0]    valid_out,
    output logic [NPORTS*DW-1:0] data_out,
    output logic [NPORTS*AW-1:0] addr_out,
    output cnt_t                 drop_cnt,
    output cnt_t                 bad_addr_cnt
);
    logic [NPORTS-1:0]    w_full, w_empty, w_accept, w_push, w_pop;
    logic [NPORTS-1:0]    w_cand_vld, w_granted, w_drop, w_bad;
    beat_t                w_head [NPORTS];
    beat_t                w_in   [NPORTS];
    beat_t                w_cand [NPORTS];
    logic [NPORTS-1:0]    w_req  [NPORTS];
    pick_t                w_pick [NPORTS];

    port_idx_t            r_ptr  [NPORTS];
    logic [NPORTS-1:0]    r_valid;
    logic [NPORTS*DW-1:0] r_data;
    logic [NPORTS*AW-1:0] r_addr;
    cnt_t                 r_drop;
    cnt_t                 r_bad;

    assign ready_in = reset ? '0 : ~w_full;

    for (genvar p = 0; p < NPORTS; p++) begin : g_in
        assign w_in[p]     = '{data: data_in[p*DW +: DW], dst: addr_in[p*AW +: PW]};
        assign w_drop[p]   = valid_in[p] && w_full[p];
        assign w_bad[p]    = valid_in[p] && !w_full[p] && (addr_in[p*AW +: AW] >= AW'(NPORTS));
        assign w_accept[p] = valid_in[p] && !w_full[p] && !w_bad[p];
`ifdef SWITCH_ARB_BYPASS_EN
        assign w_cand_vld[p] = !w_empty[p] || w_accept[p];
        assign w_cand[p]     = w_empty[p] ? w_in[p] : w_head[p];
        assign w_push[p]     = w_accept[p] && !(w_empty[p] && w_granted[p]);
`else
        assign w_cand_vld[p] = !w_empty[p];
        assign w_cand[p]     = w_head[p];
        assign w_push[p]     = w_accept[p];
`endif
        assign w_pop[p] = w_granted[p] && !w_empty[p];

        switch_in_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .i_push  (w_push[p]),
            .i_beat  (w_in[p]),
            .i_pop   (w_pop[p]),
            .o_full  (w_full[p]),
            .o_empty (w_empty[p]),
            .o_head  (w_head[p])
        );
    end

    // Each candidate addresses exactly one output, so an input is granted at most once.
    always_comb begin
        w_granted = '0;
        for (int q = 0; q < NPORTS; q++) begin
            w_req[q] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                w_req[q][i] = w_cand_vld[i] && (w_cand[i].dst == port_idx_t'(q));
            end
            w_pick[q] = rr_pick(w_req[q], r_ptr[q]);
            if (w_pick[q].vld) w_granted[w_pick[q].idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_data  <= '0;
            r_addr  <= '0;
            r_drop  <= '0;
            r_bad   <= '0;
            for (int q = 0; q < NPORTS; q++) r_ptr[q] <= '0;
        end else begin
            for (int q = 0; q < NPORTS; q++) begin
                r_valid[q] <= w_pick[q].vld;
                if (w_pick[q].vld) begin
                    r_data[q*DW +: DW] <= w_cand[w_pick[q].idx].data;
                    r_addr[q*AW +: AW] <= AW'(w_pick[q].idx);
                    r_ptr[q]           <= port_idx_t'((int'(w_pick[q].idx) + 1) % NPORTS);
                end
            end
            r_drop <= sat_add(r_drop, $countones(w_drop));
            r_bad  <= sat_add(r_bad, $countones(w_bad));
        end
    end

    assign valid_out    = r_valid;
    assign data_out     = reset ? 'z : r_data;
    assign addr_out     = reset ? 'z : r_addr;
    assign drop_cnt     = r_drop;
    assign bad_addr_cnt = r_bad;
endmodule
